updown_count_sequencer: RTL and testbench
=========================================

// Module: updown_count_sequencer
// PURPOSE
//  Command-driven sequencer for the 2-bit JK-style up/down counter datapath.
//  Accepts "count N steps in direction m" over a valid/ready handshake and steps the
//  count register once per clock. It reports wrap events and signals completion or abort.
//  It sits between a host/control FSM and any logic that consumes the count value q.
// PARAMETERS
//  WIDTH   2  count register width; count wraps modulo 2**WIDTH
//  LEN_W   8  width of cmd_steps (max steps per command = 2**LEN_W-1)
//  WCNT_W  8  width of wrap_cnt event counter
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       high only in IDLE; handshake = cmd_valid & cmd_ready at posedge
//  cmd_m      in   1       direction: 0 = up, 1 = down (same m encoding as the counter)
//  cmd_steps  in   LEN_W   number of steps to take
//  abort      in   1       stop current command (sampled only in RUN)
//  m          out  1       direction currently applied
//  q          out  WIDTH   count value; persists across commands
//  busy       out  1       high in RUN
//  done       out  1       one-cycle pulse in DONE
//  aborted    out  1       valid with done: 1 = command ended by abort
//  wrap_cnt   out  WCNT_W  wrap/reversal events since reset; saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE, q=0, m=0, remaining=0, wrap_cnt=0, busy=0, done=0, aborted=0; cmd_ready=1.
//  - Reset mid-command drops the command with no done pulse. Reset overrides everything.
//  - All outputs are registered or decoded from the state register. No comb path from inputs.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: on handshake, latch m<=cmd_m and remaining<=cmd_steps.
//          Go to RUN if cmd_steps!=0; otherwise go straight to DONE with q unchanged.
//    RUN:  each posedge with abort=0: q<=q+1 (m=0) or q-1 (m=1), mod 2**WIDTH,
//          and remaining<=remaining-1. When remaining==1 at that edge, go to DONE.
//          Each posedge with abort=1: no step, aborted<=1, go to DONE.
//          Abort wins over a coincident last step.
//    DONE: done=1 for exactly one cycle, then IDLE. aborted clears on the next handshake.
//  - Latency: handshake at edge T, N>0 steps -> q updates at edges T+1..T+N.
//    done is high in cycle after edge T+N. cmd_ready returns at edge T+N+1.
//  - Wrap event: up step from all-ones, or down step from zero. wrap_cnt+1, saturating.
//  - cmd_valid outside IDLE is ignored and does not stall.
//  - cmd_* need only be stable in the handshake cycle.
// CONFIGURATION
//  UDSEQ_BOUNCE_EN defined: ping-pong mode.
//    A step that would wrap instead reverses: m toggles, and q moves one step in the new direction.
//    The step is still consumed and wrap_cnt counts each reversal.
//    The new m persists into later commands until the next handshake reloads it.
//  UDSEQ_BOUNCE_EN undefined: plain modulo wrap as above. m is constant within a command.
// TESTING (WIDTH=2 unless noted)
//  1. Assert reset 2 cycles mid-RUN -> next cycle q=0, m=0, cmd_ready=1, done=0, wrap_cnt=0.
//  2. From q=0, cmd_m=0, steps=5 -> q=1,2,3,0,1 on edges T+1..T+5.
//     done=1 and aborted=0 in the next cycle, wrap_cnt=1.
//  3. From q=1, cmd_m=1, steps=3 -> q=0,3,2; wrap_cnt+1; busy high exactly 3 cycles.
//  4. steps=0 -> done pulse in the cycle after handshake; q unchanged; busy never high.
//  5. steps=10, abort in the cycle with remaining==8 -> q advanced 2, done=1, aborted=1.
//     Also: abort coincident with the last step -> step not taken, aborted=1.
//  6. UDSEQ_BOUNCE_EN, from q=0, cmd_m=0, steps=6 -> q=1,2,3,2,1,0; m=1 after edge T+4.
//     wrap_cnt=1. Also hold cmd_valid during RUN -> no second accept until IDLE.

Source files
------------

// File: rtl/updown_count_sequencer_if.sv
// Command/status bundle for updown_count_sequencer: host-side command handshake
// plus the registered count/status outputs. master = host, slave = sequencer.
interface updown_count_sequencer_if #(
  parameter int WIDTH  = 2,
  parameter int LEN_W  = 8,
  parameter int WCNT_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_m;
  logic [LEN_W-1:0]  cmd_steps;
  logic              abort;
  logic              m;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [WCNT_W-1:0] wrap_cnt;

  modport master (
    output cmd_valid, cmd_m, cmd_steps, abort,
    input  cmd_ready, m, q, busy, done, aborted, wrap_cnt
  );

  modport slave (
    input  cmd_valid, cmd_m, cmd_steps, abort,
    output cmd_ready, m, q, busy, done, aborted, wrap_cnt
  );
endinterface

// File: rtl/updown_count_sequencer.sv
// Command-driven sequencer stepping a WIDTH-bit up/down count once per clock.
// Optional macro UDSEQ_BOUNCE_EN: a would-be wrap reverses direction (ping-pong).
module updown_count_sequencer #(
  parameter int WIDTH  = 2,
  parameter int LEN_W  = 8,
  parameter int WCNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  updown_count_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic              m_r;
  logic [WIDTH-1:0]  q_r;
  logic              aborted_r;
  logic [WCNT_W-1:0] wrap_cnt_r;

  logic              accept;
  logic              step_en;
  logic              wrap_hit;
  logic              m_step;
  logic [WIDTH-1:0]  q_step;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign step_en  = (state == RUN) && !bus.abort;
  assign wrap_hit = m_r ? (q_r == '0) : (q_r == '1);

`ifdef UDSEQ_BOUNCE_EN
  // A step that would wrap flips direction and moves one step the other way.
  assign m_step = wrap_hit ? ~m_r : m_r;
`else
  assign m_step = m_r;
`endif

  assign q_step = m_step ? (q_r - WIDTH'(1)) : (q_r + WIDTH'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.cmd_steps != '0) ? RUN : DONE;
      RUN:  if (bus.abort || remaining == LEN_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_r        <= 1'b0;
      q_r        <= '0;
      remaining  <= '0;
      aborted_r  <= 1'b0;
      wrap_cnt_r <= '0;
    end else begin
      if (accept) begin
        m_r       <= bus.cmd_m;
        remaining <= bus.cmd_steps;
        aborted_r <= 1'b0;
      end
      if (state == RUN && bus.abort) aborted_r <= 1'b1;
      if (step_en) begin
        q_r       <= q_step;
        m_r       <= m_step;
        remaining <= remaining - LEN_W'(1);
        if (wrap_hit && wrap_cnt_r != '1) wrap_cnt_r <= wrap_cnt_r + WCNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.m         = m_r;
  assign bus.q         = q_r;
  assign bus.aborted   = aborted_r;
  assign bus.wrap_cnt  = wrap_cnt_r;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed bench for updown_count_sequencer (WIDTH=2); define UDSEQ_BOUNCE_EN
// to exercise ping-pong mode instead of the modulo-wrap scenarios.
module tb_updown_count_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  updown_count_sequencer_if #(.WIDTH(2), .LEN_W(8), .WCNT_W(8)) sif ();

  updown_count_sequencer #(.WIDTH(2), .LEN_W(8), .WCNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Offers one command for one cycle; returns just after the handshake edge.
  task automatic send(input logic dir, input logic [7:0] steps);
    sif.cmd_valid = 1'b1;
    sif.cmd_m     = dir;
    sif.cmd_steps = steps;
    tick();
    sif.cmd_valid = 1'b0;
    sif.cmd_steps = 8'hxx;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sif.q, sif.m, sif.cmd_ready, sif.busy, sif.done, sif.aborted} !== 6'b00_0_1_0_0_0) begin
      errors++;
      $display("FAIL reset_state got q=%0d m=%b rdy=%b busy=%b done=%b ab=%b",
               sif.q, sif.m, sif.cmd_ready, sif.busy, sif.done, sif.aborted);
    end
    checks++;
    if (sif.wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_wrap_cnt got %0d exp 0", sif.wrap_cnt);
    end
    // Reset asserted for two cycles in the middle of a running command.
    send(1'b0, 8'd5);
    tick();
    tick();
    do_reset();
    checks++;
    if ({sif.q, sif.m, sif.cmd_ready, sif.busy, sif.done, sif.wrap_cnt} !== {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL midrun_reset got q=%0d m=%b rdy=%b busy=%b done=%b wc=%0d",
               sif.q, sif.m, sif.cmd_ready, sif.busy, sif.done, sif.wrap_cnt);
    end
    tick();
    checks++;
    if ({sif.done, sif.cmd_ready, sif.q} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL midrun_no_done got done=%b rdy=%b q=%0d exp 0 1 0", sif.done, sif.cmd_ready, sif.q);
    end
  endtask

`ifndef UDSEQ_BOUNCE_EN
  task automatic test_count_up();
    logic [1:0] exp_q [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    send(1'b0, 8'd5);
    checks++;
    if ({sif.busy, sif.cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL up_enter_run got busy=%b rdy=%b exp 1 0", sif.busy, sif.cmd_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (sif.q !== exp_q[k]) begin
        errors++;
        $display("FAIL up_step%0d got q=%0d exp %0d", k + 1, sif.q, exp_q[k]);
      end
    end
    checks++;
    if ({sif.done, sif.aborted, sif.busy, sif.cmd_ready, sif.m, sif.wrap_cnt} !== {5'b1_0_0_0_0, 8'd1}) begin
      errors++;
      $display("FAIL up_done got done=%b ab=%b busy=%b rdy=%b m=%b wc=%0d exp 1 0 0 0 0 1",
               sif.done, sif.aborted, sif.busy, sif.cmd_ready, sif.m, sif.wrap_cnt);
    end
    tick();
    checks++;
    if ({sif.done, sif.cmd_ready, sif.q} !== {1'b0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL up_back_idle got done=%b rdy=%b q=%0d exp 0 1 1", sif.done, sif.cmd_ready, sif.q);
    end
  endtask

  task automatic test_count_down();
    logic [1:0] exp_q [3] = '{2'd0, 2'd3, 2'd2};
    int busy_cycles = 0;
    send(1'b1, 8'd3);
    if (sif.busy) busy_cycles++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (sif.q !== exp_q[k]) begin
        errors++;
        $display("FAIL down_step%0d got q=%0d exp %0d", k + 1, sif.q, exp_q[k]);
      end
      if (sif.busy) busy_cycles++;
    end
    tick();
    if (sif.busy) busy_cycles++;
    checks++;
    if (busy_cycles !== 3) begin
      errors++;
      $display("FAIL down_busy_len got %0d cycles exp 3", busy_cycles);
    end
    checks++;
    if ({sif.m, sif.wrap_cnt, sif.cmd_ready} !== {1'b1, 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL down_end got m=%b wc=%0d rdy=%b exp 1 2 1", sif.m, sif.wrap_cnt, sif.cmd_ready);
    end
  endtask

  task automatic test_zero_steps();
    send(1'b0, 8'd0);
    checks++;
    if ({sif.done, sif.busy, sif.aborted, sif.q} !== {3'b1_0_0, 2'd2}) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b ab=%b q=%0d exp 1 0 0 2",
               sif.done, sif.busy, sif.aborted, sif.q);
    end
    tick();
    checks++;
    if ({sif.done, sif.busy, sif.cmd_ready, sif.q, sif.wrap_cnt} !== {3'b0_0_1, 2'd2, 8'd2}) begin
      errors++;
      $display("FAIL zero_idle got done=%b busy=%b rdy=%b q=%0d wc=%0d exp 0 0 1 2 2",
               sif.done, sif.busy, sif.cmd_ready, sif.q, sif.wrap_cnt);
    end
  endtask

  task automatic test_abort();
    // q=2 going up: edges T+1,T+2 take q to 3 then 0 (one wrap); abort with remaining==8.
    send(1'b0, 8'd10);
    tick();
    tick();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    checks++;
    if ({sif.done, sif.aborted, sif.q, sif.wrap_cnt} !== {2'b11, 2'd0, 8'd3}) begin
      errors++;
      $display("FAIL abort_mid got done=%b ab=%b q=%0d wc=%0d exp 1 1 0 3",
               sif.done, sif.aborted, sif.q, sif.wrap_cnt);
    end
    tick();
    checks++;
    if ({sif.cmd_ready, sif.done, sif.aborted} !== 3'b101) begin
      errors++;
      $display("FAIL abort_hold got rdy=%b done=%b ab=%b exp 1 0 1", sif.cmd_ready, sif.done, sif.aborted);
    end
    // Abort coincident with the final step: step must not be taken.
    send(1'b1, 8'd2);
    checks++;
    if (sif.aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear got ab=%b exp 0", sif.aborted);
    end
    tick();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    checks++;
    if ({sif.done, sif.aborted, sif.q, sif.wrap_cnt} !== {2'b11, 2'd3, 8'd4}) begin
      errors++;
      $display("FAIL abort_last got done=%b ab=%b q=%0d wc=%0d exp 1 1 3 4",
               sif.done, sif.aborted, sif.q, sif.wrap_cnt);
    end
    tick();
  endtask
`else
  task automatic test_bounce();
    logic [1:0] exp_q [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    logic       exp_m [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    send(1'b0, 8'd6);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({sif.q, sif.m} !== {exp_q[k], exp_m[k]}) begin
        errors++;
        $display("FAIL bounce_step%0d got q=%0d m=%b exp %0d %b", k + 1, sif.q, sif.m, exp_q[k], exp_m[k]);
      end
    end
    checks++;
    if ({sif.done, sif.wrap_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL bounce_done got done=%b wc=%0d exp 1 1", sif.done, sif.wrap_cnt);
    end
    tick();
    checks++;
    if ({sif.m, sif.cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL bounce_m_persist got m=%b rdy=%b exp 1 1", sif.m, sif.cmd_ready);
    end
  endtask
`endif

  task automatic test_hold_valid();
    do_reset();
    sif.cmd_valid = 1'b1;
    sif.cmd_m     = 1'b0;
    sif.cmd_steps = 8'd2;
    tick();
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({sif.cmd_ready, sif.busy} !== 2'b01) begin
        errors++;
        $display("FAIL hold_run%0d got rdy=%b busy=%b exp 0 1", k, sif.cmd_ready, sif.busy);
      end
      tick();
    end
    checks++;
    if ({sif.done, sif.q} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL hold_done got done=%b q=%0d exp 1 2", sif.done, sif.q);
    end
    tick();
    checks++;
    if ({sif.cmd_ready, sif.busy, sif.q} !== {2'b10, 2'd2}) begin
      errors++;
      $display("FAIL hold_idle got rdy=%b busy=%b q=%0d exp 1 0 2", sif.cmd_ready, sif.busy, sif.q);
    end
    sif.cmd_valid = 1'b0;
    tick();
    checks++;
    if ({sif.cmd_ready, sif.q} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL hold_release got rdy=%b q=%0d exp 1 2", sif.cmd_ready, sif.q);
    end
  endtask

  initial begin
    sif.cmd_valid = 1'b0;
    sif.cmd_m     = 1'b0;
    sif.cmd_steps = 8'd0;
    sif.abort     = 1'b0;
    test_reset();
`ifndef UDSEQ_BOUNCE_EN
    test_count_up();
    test_count_down();
    test_zero_steps();
    test_abort();
`else
    test_bounce();
`endif
    test_hold_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
